// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter and its watchdog.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int WD_W = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: fires for one cycle once a strobe has waited TIMEOUT cycles
// without a termination. A same-cycle termination always beats the fire.
module wb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  input  logic done,
  output logic fire
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] count_q;
  logic [WD_W-1:0] count_d;
  logic            at_limit;

  assign at_limit = (count_q == LIMIT);

  always_comb begin
    fire    = busy && !done && at_limit;
    count_d = count_q + WD_W'(1);
    // Reaching the limit restarts the count whether it fired or was beaten by done.
    if (clr || !busy || done || at_limit) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter: registered round-robin
// grant held for the whole bus cycle, with a stall watchdog answering err.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [AW-1:0]     m0_adr,
  input  logic [DW-1:0]     m0_dat,
  input  logic [DW/8-1:0]   m0_sel,
  input  logic              m0_we,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  output logic [DW-1:0]     m0_rdt,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [AW-1:0]     m1_adr,
  input  logic [DW-1:0]     m1_dat,
  input  logic [DW/8-1:0]   m1_sel,
  input  logic              m1_we,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  output logic [DW-1:0]     m1_rdt,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dat,
  output logic [DW/8-1:0]   s_sel,
  output logic              s_we,
  output logic              s_cyc,
  output logic              s_stb,
  input  logic [DW-1:0]     s_rdt,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [1:0]        grant
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;   // 0 = m0 owned last, 1 = m1 owned last
  logic       own0, own1;
  logic       owner_stb;
  logic       wd_fire;

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign grant = grant_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the master that did not own the bus last wins.
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = ST_OWN0;
        end else if (m1_cyc) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? ST_OWN0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    grant_d = GRANT_NONE;
    if (state_d == ST_OWN0) begin
      grant_d = GRANT_M0;
    end else if (state_d == ST_OWN1) begin
      grant_d = GRANT_M1;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_NONE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_adr     = '0;
    s_dat     = '0;
    s_sel     = '0;
    s_we      = 1'b0;
    s_cyc     = 1'b0;
    owner_stb = 1'b0;
    if (own0) begin
      s_adr     = m0_adr;
      s_dat     = m0_dat;
      s_sel     = m0_sel;
      s_we      = m0_we;
      s_cyc     = m0_cyc;
      owner_stb = m0_stb;
    end else if (own1) begin
      s_adr     = m1_adr;
      s_dat     = m1_dat;
      s_sel     = m1_sel;
      s_we      = m1_we;
      s_cyc     = m1_cyc;
      owner_stb = m1_stb;
    end
  end

  // A fire withdraws the strobe so the slave never sees the abandoned request.
  assign s_stb = owner_stb & ~wd_fire;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .clr  (state_d != state_q),
    .busy (owner_stb),
    .done (s_ack | s_err),
    .fire (wd_fire)
  );

  assign m0_ack = own0 & s_ack;
  assign m0_err = own0 & (s_err | wd_fire);
  assign m0_rdt = own0 ? s_rdt : '0;
  assign m1_ack = own1 & s_ack;
  assign m1_err = own1 & (s_err | wd_fire);
  assign m1_rdt = own1 ? s_rdt : '0;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed arbitration scenarios plus
// randomized traffic, responses checked by a queue-based scoreboard.
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat, m1_dat, s_dat;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [DW-1:0] m0_rdt, m1_rdt, s_rdt;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]    grant;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdt(m0_rdt), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdt(m1_rdt), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_rdt(s_rdt), .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        wd;
    logic [31:0] rdt;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [1:0] glog[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slave memory contents: writes echo data folded with the byte selects,
  // reads return the inverted address, one well-known word at 0x0004_0000.
  function automatic logic [31:0] slave_data(logic [31:0] adr, logic we, logic [31:0] dat,
                                             logic [3:0] sel);
    if (we) return dat ^ {8{sel}};
    if (adr == 32'h0004_0000) return 32'hDEADBEEF;
    return ~adr;
  endfunction

  // Address bits [18:16] choose the slave's behaviour: 0..4 ack after that many
  // wait states, 5 slave error after one wait state, 6..7 never answer.
  function automatic exp_t ref_resp(logic [31:0] adr, logic we, logic [31:0] dat, logic [3:0] sel);
    exp_t e;
    int   w;
    e = '0;
    w = int'(adr[18:16]);
    if (w == 5) begin
      e.err = 1'b1;
    end else if (w <= TO) begin
      e.ack = 1'b1;
      e.rdt = slave_data(adr, we, dat, sel);
    end else begin
      e.err = 1'b1;
      e.wd  = 1'b1;
    end
    return e;
  endfunction

  // Behavioural slave.
  initial begin
    int cnt;
    int w;
    cnt = 0;
    s_ack = 1'b0; s_err = 1'b0; s_rdt = '0;
    forever begin
      @(posedge wb_clk);
      #2;
      s_ack = 1'b0; s_err = 1'b0; s_rdt = '0;
      #1;
      if (s_cyc && (s_stb || m0_err || m1_err)) begin
        w = int'(s_adr[18:16]);
        if (w <= 4 && cnt == w) begin
          s_ack = 1'b1;
          s_rdt = slave_data(s_adr, s_we, s_dat, s_sel);
          cnt = 0;
        end else if (w == 5 && cnt == 1) begin
          s_err = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic drive(input int m, input logic cyc, input logic stb, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic we);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we;
    end
  endtask

  function automatic logic [33:0] resp_of(int m);
    return (m == 0) ? {m0_ack, m0_err, m0_rdt} : {m1_ack, m1_err, m1_rdt};
  endfunction

  // One bus cycle of nb beats; lat = negedges from first strobe to first response.
  task automatic m_cycle(input int m, input int nb, input logic [2:0] w, input logic [15:0] off,
                         input int we_mode, output int lat);
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we;
    logic [33:0] r;
    int          n;
    lat = 0;
    @(posedge wb_clk); #1;
    for (int b = 0; b < nb; b++) begin
      adr = {13'd0, w, off + 16'(4 * b)};
      dat = $urandom;
      sel = 4'($urandom_range(1, 15));
      we  = (we_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(we_mode);
      if (m == 0) q0.push_back(ref_resp(adr, we, dat, sel));
      else        q1.push_back(ref_resp(adr, we, dat, sel));
      drive(m, 1'b1, 1'b1, adr, dat, sel, we);
      n = 0;
      r = '0;
      while (r[33:32] == 2'b00 && n < 50) begin
        @(negedge wb_clk);
        n++;
        r = resp_of(m);
      end
      if (b == 0) lat = n;
      chk($sformatf("m%0d_resp_seen", m), 64'(r[33:32] != 2'b00), 64'd1);
      @(posedge wb_clk); #1;
      if (r[33:32] != 2'b01 && r[33:32] != 2'b10) break;
      if (r[32]) break;
    end
    drive(m, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic check_port(input int m);
    logic [33:0] r;
    logic [1:0]  gbit;
    exp_t        e;
    r    = resp_of(m);
    gbit = (m == 0) ? 2'b01 : 2'b10;
    if (grant != gbit) chk($sformatf("m%0d_nonowner_quiet", m), 64'(r), 64'd0);
    if (r[33:32] != 2'b00) begin
      if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
        chk($sformatf("m%0d_unexpected_resp", m), 64'(r), 64'd0);
      end else begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("m%0d_resp", m), 64'(r), 64'({e.ack, e.err, e.rdt}));
        chk($sformatf("m%0d_resp_grant", m), 64'(grant), 64'(gbit));
        if (e.wd) chk($sformatf("m%0d_wd_stb_masked", m), 64'(s_stb), 64'd0);
        $display("txn m%0d ack=%0b err=%0b rdt=%08h grant=%02b", m, r[33], r[32], r[31:0], grant);
      end
    end
  endtask

  // Monitor.
  initial begin
    forever begin
      @(negedge wb_clk);
      glog.push_back(grant);
      if (!wb_rst) begin
        check_port(0);
        check_port(1);
      end
    end
  end

  // Encodes the sequence of distinct grant values seen, two bits per run.
  function automatic logic [31:0] runs_code();
    logic [31:0] code;
    logic [1:0]  prev;
    code = '0;
    prev = 2'b11;
    foreach (glog[i]) begin
      if (glog[i] != prev) code = {code[29:0], glog[i]};
      prev = glog[i];
    end
    return code;
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int lat, lat0, lat1;
    wb_rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_slave_req", 64'({s_cyc, s_stb, s_we, s_adr, s_sel}), 64'd0);
    chk("rst_m_resp", 64'({m0_ack, m0_err, m1_ack, m1_err, m0_rdt ^ m1_rdt}), 64'd0);
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;

    // Simultaneous request: m0 first, then m1 without an idle gap.
    glog.delete();
    fork
      m_cycle(0, 1, 3'd2, 16'h0010, 0, lat0);
      m_cycle(1, 1, 3'd0, 16'h0020, 1, lat1);
    join
    repeat (3) @(negedge wb_clk);
    chk("tie_order_runs", 64'(runs_code()), 64'(8'b00_01_10_00));
    chk("tie_m0_latency", 64'(lat0), 64'd4);

    // m1 three-beat cycle holds the bus while m0 waits.
    glog.delete();
    fork
      m_cycle(1, 3, 3'd1, 16'h0100, 0, lat1);
      begin
        repeat (2) @(posedge wb_clk);
        m_cycle(0, 1, 3'd0, 16'h0200, 2, lat0);
      end
    join
    repeat (3) @(negedge wb_clk);
    chk("hold_runs", 64'(runs_code()), 64'(8'b00_10_01_00));

    // Back-to-back traffic from both masters alternates strictly.
    glog.delete();
    fork
      repeat (4) m_cycle(0, 1, 3'($urandom_range(0, 4)), 16'($urandom_range(0, 255) * 16), 2, lat0);
      begin
        @(posedge wb_clk);
        repeat (4) m_cycle(1, 1, 3'($urandom_range(0, 4)), 16'($urandom_range(0, 255) * 16), 2, lat1);
      end
    join
    repeat (3) @(negedge wb_clk);
    chk("alternate_runs", 64'(runs_code()), 64'(20'b00_01_10_01_10_01_10_01_10_00));

    // Watchdog, ack-beats-fire, and slave error.
    m_cycle(1, 1, 3'd7, 16'h2000, 0, lat);
    chk("wd_err_latency", 64'(lat), 64'(TO + 2));
    repeat (2) @(posedge wb_clk);
    m_cycle(0, 1, 3'd4, 16'h0000, 0, lat);
    chk("ack_vs_fire_latency", 64'(lat), 64'(TO + 2));
    repeat (2) @(posedge wb_clk);
    m_cycle(0, 1, 3'd5, 16'h0040, 2, lat);
    chk("slave_err_latency", 64'(lat), 64'd3);
    repeat (2) @(posedge wb_clk);

    // Reset while m1 owns the bus with a stalled strobe.
    @(posedge wb_clk); #1;
    drive(1, 1'b1, 1'b1, 32'h0007_3000, 32'h0, 4'hf, 1'b0);
    repeat (2) @(posedge wb_clk);
    #1 wb_rst = 1'b1;
    @(negedge wb_clk);
    chk("pre_rst_grant", 64'(grant), 64'd2);
    @(posedge wb_clk);
    @(negedge wb_clk);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_cyc_stb", 64'({s_cyc, s_stb}), 64'd0);
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    glog.delete();
    fork
      m_cycle(0, 1, 3'd0, 16'h0300, 2, lat0);
      m_cycle(1, 1, 3'd1, 16'h0400, 2, lat1);
    join
    repeat (3) @(negedge wb_clk);
    chk("post_rst_tie_runs", 64'(runs_code()), 64'(8'b00_01_10_00));

    // Randomized independent traffic.
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge wb_clk);
        m_cycle(0, $urandom_range(1, 3), 3'($urandom_range(0, 7)),
                16'($urandom_range(0, 4000) * 16), 2, lat0);
      end
      for (int j = 0; j < 12; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge wb_clk);
        m_cycle(1, $urandom_range(1, 3), 3'($urandom_range(0, 7)),
                16'($urandom_range(0, 4000) * 16), 2, lat1);
      end
    join

    repeat (5) @(negedge wb_clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone classic arbiter.
- Lets the core's instruction bus (m0) and data bus (m1) share a single slave port, e.g. the RAM or the intercon's slave side.
- Registered round-robin grant held for the whole bus cycle, with a watchdog that terminates hung transfers with err.

Parameters:
AW, 32, address width
DW, 32, data width (select width = DW/8)
TIMEOUT, 255, cycles of stb without ack/err before the watchdog fires (1..65535)

Ports:
wb_clk  in  1  clock
wb_rst  in  1  synchronous active-high reset
m0_adr/m0_dat/m0_sel/m0_we/m0_cyc/m0_stb  in  AW/DW/DW/8/1/1/1  master 0 request (instruction bus)
m0_rdt  out  DW  read data to master 0
m0_ack  out  1  ack to master 0
m0_err  out  1  error to master 0
m1_adr/m1_dat/m1_sel/m1_we/m1_cyc/m1_stb  in  AW/DW/DW/8/1/1/1  master 1 request (data bus)
m1_rdt/m1_ack/m1_err  out  DW/1/1  responses to master 1
s_adr/s_dat/s_sel/s_we/s_cyc/s_stb  out  AW/DW/DW/8/1/1/1  slave request
s_rdt  in  DW  slave read data
s_ack  in  1  slave ack
s_err  in  1  slave error
grant  out  2  one-hot current owner (01=m0, 10=m1, 00=idle)

Behaviour:
- Reset: one clock, synchronous active-high.
  - State IDLE, grant=00, last_owner=m1 (m0 wins the first tie), watchdog=0.
  - All s_* outputs 0; all m*_ack/m*_err/m*_rdt 0.
- States: IDLE, OWN0, OWN1.
  - IDLE: m0_cyc only -> OWN0; m1_cyc only -> OWN1; both -> the master that is not last_owner.
  - Grant is registered: 1-cycle arbitration latency from cyc rising to s_cyc.
- OWNx: hold while mx_cyc=1, even across multiple stb/ack beats (no preemption).
  - On mx_cyc=0: if the other master's cyc=1, go directly to OWN(other) next cycle; else IDLE.
  - Update last_owner=x on leaving.
- Slave outputs are a combinational mux of the owner's request lines.
  - s_cyc = owner cyc; s_stb = owner stb & ~wd_fire.
  - In IDLE, all s_* are 0.
- Responses:
  - Owner receives s_ack and s_rdt.
  - Owner receives err = s_err | wd_fire.
  - Non-owner sees ack=0, err=0, rdt=0.
- Watchdog:
  - 16-bit counter; increments while owner stb=1 and s_ack=0 and s_err=0.
  - Clears on ack, err, stb=0, or ownership change.
  - wd_fire is combinational, asserted when counter==TIMEOUT: one-cycle err to the owner, s_stb masked that cycle, counter cleared next cycle.
- Simultaneous s_ack and wd_fire: ack wins; err is suppressed and the counter is cleared.
- Owner drops cyc on the same cycle as ack: legal; handoff proceeds as above.
- Non-owner raising cyc mid-transfer: waits, with no response and no side effects.
- Reset mid-transfer: grant and state return to IDLE next edge; s_cyc/s_stb are 0 in the cycle after reset is sampled.
- Not supported: cti/bte bursts, which are treated as classic cycles.

Decomposition:
- Shared package (wb_arb_pkg):
  - state encoding constants IDLE/OWN0/OWN1
  - grant one-hot constants
  - watchdog counter width localparam (16)
- One sub-module: wb_watchdog.
  - Inputs: clk, rst, clr, busy, done.
  - Outputs: fire.
  - Parameterised by TIMEOUT; reusable for other bus masters.
- Arbiter FSM and muxes stay in wb_arbiter2.

Test Plan:
- Reset then m0_cyc=m1_cyc=1 at the same edge -> grant=01 one cycle later; after m0 drops cyc, grant=10 next cycle with no IDLE gap.
- m1 holds cyc for 3 beats (adr 0x100, 0x104, 0x108; slave acks each after 1 wait) while m0 requests -> m0_ack stays 0 throughout; m0 granted the cycle after m1_cyc falls.
- Alternating back-to-back requests from both masters for 8 transactions -> strict grant order m0, m1, m0, m1, ...; no master starved.
- TIMEOUT=4, slave never acks m1 read at 0x2000 -> m1_err=1 for exactly one cycle after 4 stalled cycles; s_stb=0 that cycle; m1_ack never set.
- s_ack and watchdog fire on the same cycle (slave acks on cycle TIMEOUT) -> m0_ack=1, m0_err=0, m0_rdt = s_rdt (0xDEADBEEF).
- wb_rst asserted while OWN1 with stb pending -> next cycle grant=00, s_cyc=0, s_stb=0; after release, m0 wins the first tie.
